keypad_scan_ctrl: RTL and testbench

Matrix-keypad scan controller that sequences a 4x4 keypad and feeds the password/onehot decoder. It drives the rows and samples the columns, debounces a single key, and emits one clean single-cycle one-hot pulse per press. The decoder therefore never sees bounce, ghost keys or a held key repeated every clock. It sits between the board keypad pins and the decoder's `onehot` input.

---
 rtl/keypad_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan controller for a 4x4 matrix keypad. It drives one row low at a time and
// samples the active-low columns. A single pressed key is debounced and
// reported as one clean single-cycle one-hot pulse, so the downstream decoder
// never sees bounce, ghost keys or a held key repeated on every clock.
//
// Parameters
//   SCAN_DIV       clk cycles per scan tick (>= 4)
//   DEBOUNCE_TICKS consecutive identical ticks to accept a press or release (1..15)
//   REPEAT_TICKS   auto-repeat period in ticks (only with KEYPAD_REPEAT_EN)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col_in     keypad columns, active-low, asynchronous to clk
//   row_out    keypad row drive, active-low, exactly one bit low
//   onehot     bit row*4+col high for one clk per accepted press
//   key_valid  high in the same cycle as onehot != 0
//   key_code   row*4+col of the last accepted key
//   key_down   high from acceptance until the release is accepted
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, a held key re-emits its pulse every
//                     REPEAT_TICKS ticks.
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_TICKS   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down
);

  localparam int unsigned DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_LIMIT = 4'(DEBOUNCE_TICKS);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W     = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(REPEAT_TICKS);
`endif

  // Column of the single low bit in a pattern that has exactly one low bit.
  function automatic logic [1:0] low_col(input logic [3:0] cols);
    case (cols)
      4'b1101: low_col = 2'd1;
      4'b1011: low_col = 2'd2;
      4'b0111: low_col = 2'd3;
      default: low_col = 2'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Column synchronizer: col_in is asynchronous, so every decision below looks
  // only at col_s_q. Columns are pulled up, hence the all-ones reset value.
  // ---------------------------------------------------------------------------
  logic [3:0] col_meta_q, col_s_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       pat_q, pat_d;     // latched column pattern of the candidate key
  logic [3:0]       cnt_q, cnt_d;     // matching press ticks
  logic [3:0]       rel_q, rel_d;     // consecutive all-high ticks while held
  logic [15:0]      onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic             down_q, down_d;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
`endif

  logic       tick;
  logic       single_low;
  logic       accept;
  logic [3:0] new_cnt;
  logic [3:0] rel_inc;

  assign tick       = (div_cnt_q == DIV_LAST);
  assign single_low = (col_s_q == 4'b1110) || (col_s_q == 4'b1101) ||
                      (col_s_q == 4'b1011) || (col_s_q == 4'b0111);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    state_d   = state_q;
    row_d     = row_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    onehot_d  = '0;
    valid_d   = 1'b0;
    code_d    = code_q;
    down_d    = down_q;
    accept    = 1'b0;
    new_cnt   = cnt_q;
    rel_inc   = rel_q + 4'd1;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
    rep_inc   = rep_q + REP_W'(1);
`endif

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (single_low) begin
            // Row stays put so the same key keeps being sampled.
            pat_d   = col_s_q;
            new_cnt = 4'd1;
            cnt_d   = new_cnt;
            state_d = ST_DEBOUNCE;
            accept  = (new_cnt == DEB_LIMIT);
          end else begin
            // Idle, multi-key and ghost patterns all just move on.
            row_d = row_q + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (col_s_q == pat_q) begin
            new_cnt = cnt_q + 4'd1;
            cnt_d   = new_cnt;
            accept  = (new_cnt == DEB_LIMIT);
          end else begin
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
          end
        end

        ST_HELD: begin
          // Any low column (including a second key) restarts the release count.
          if (col_s_q == 4'hF) begin
            if (rel_inc == DEB_LIMIT) begin
              rel_d   = '0;
              down_d  = 1'b0;
              state_d = ST_SCAN;
              row_d   = row_q + 2'd1;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (col_s_q == pat_q) begin
            if (rep_inc == REP_LIMIT) begin
              onehot_d = 16'd1 << code_q;
              valid_d  = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_inc;
            end
          end else begin
            rep_d = '0;
          end
`endif
        end

        default: state_d = ST_SCAN;
      endcase
    end

    if (accept) begin
      state_d  = ST_HELD;
      code_d   = {row_q, low_col(pat_d)};
      onehot_d = 16'd1 << code_d;
      valid_d  = 1'b1;
      down_d   = 1'b1;
      rel_d    = '0;
`ifdef KEYPAD_REPEAT_EN
      rep_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      state_q   <= ST_SCAN;
      row_q     <= 2'd0;
      pat_q     <= 4'hF;
      cnt_q     <= '0;
      rel_q     <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      down_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      down_q    <= down_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign onehot    = onehot_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Drives keypad_scan_ctrl through a simulated 4x4 key matrix. A tick-level
// behavioural model predicts every output on every cycle; a few hand-computed
// literal expectations pin the model to the documented timing.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] pressed = '0;   // bit row*4+col = key held down on the board

  keypad_scan_ctrl #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_TICKS(DEB),
    .REPEAT_TICKS  (REP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_out  (row_out),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a column reads low when a pressed key joins it to a
  // driven-low row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col_in[c] = 1'b0;
  end

  // Cycle index since reset release; cycle 0 is the one in which rst_n rises.
  int cyc = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      if (errors >= 50) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model, evaluated once per cycle. Columns seen by the
  // controller are the pin values from two cycles earlier.
  // ---------------------------------------------------------------------------
  typedef enum {M_SCAN, M_CONFIRM, M_HOLD} mode_e;
  mode_e       mode;
  int          row, cnt, rel, rep, key;
  logic [3:0]  pat, h1, h2;
  logic [3:0]  exp_row, exp_code;
  logic [15:0] exp_onehot;
  logic        exp_valid, exp_down;

  task automatic model_reset();
    mode = M_SCAN; row = 0; cnt = 0; rel = 0; rep = 0; key = 0;
    pat = 4'hF; h1 = 4'hF; h2 = 4'hF;
    exp_row = 4'b1110; exp_code = 4'd0; exp_onehot = '0;
    exp_valid = 1'b0; exp_down = 1'b0;
  endtask

  task automatic emit(input int k);
    exp_onehot = 16'h1 << k;
    exp_valid  = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] cin);
    logic [3:0] cs;
    int low_n, low_c;
    cs = h2; h2 = h1; h1 = cin;
    exp_onehot = '0;
    exp_valid  = 1'b0;
    if (cyc % SCAN_DIV == SCAN_DIV - 1) begin
      low_n = 0; low_c = 0;
      for (int c = 0; c < 4; c++)
        if (!cs[c]) begin low_n++; low_c = c; end
      case (mode)
        M_SCAN:
          if (low_n == 1) begin
            pat = cs; key = row*4 + low_c; cnt = 1; mode = M_CONFIRM;
          end else row = (row + 1) % 4;
        M_CONFIRM:
          if (cs == pat) cnt++;
          else begin mode = M_SCAN; row = (row + 1) % 4; end
        M_HOLD: begin
          if (cs == 4'hF) rel++; else rel = 0;
`ifdef KEYPAD_REPEAT_EN
          if (cs == pat) begin
            rep++;
            if (rep == REP) begin emit(key); rep = 0; end
          end else rep = 0;
`endif
          if (rel == DEB) begin
            exp_down = 1'b0; mode = M_SCAN; row = (row + 1) % 4;
          end
        end
        default: mode = M_SCAN;
      endcase
      if (mode == M_CONFIRM && cnt == DEB) begin
        emit(key);
        exp_code = key[3:0];
        exp_down = 1'b1;
        mode = M_HOLD; rel = 0; rep = 0;
      end
      exp_row = 4'hF;
      exp_row[row] = 1'b0;
    end
  endtask

  // Compare process: every cycle, outputs against the model (or reset values).
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset row_out",   {28'd0, row_out},  32'hE);
      check("reset onehot",    {16'd0, onehot},   32'h0);
      check("reset key_valid", {31'd0, key_valid}, 32'h0);
      check("reset key_code",  {28'd0, key_code}, 32'h0);
      check("reset key_down",  {31'd0, key_down}, 32'h0);
      model_reset();
    end else begin
      check("row_out",   {28'd0, row_out},   {28'd0, exp_row});
      check("onehot",    {16'd0, onehot},    {16'd0, exp_onehot});
      check("key_valid", {31'd0, key_valid}, {31'd0, exp_valid});
      check("key_code",  {28'd0, key_code},  {28'd0, exp_code});
      check("key_down",  {31'd0, key_down},  {31'd0, exp_down});
      if (key_valid) pulses++;
      model_step(col_in);
    end
  end

  // Advance to the sampling point of cycle n (must lie in the future).
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("wait_cyc timeout", cyc, n);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int r, hold, a, b;
    model_reset();
    rst_n   = 1'b0;
    pressed = 16'h0100;               // row 2 col 0 held through reset
    @(posedge clk);
    do_reset(3);                      // rst_n rises at the start of cycle 0

    // Reset and first row step.
    wait_cyc(0);
    check("lit row_out c0", {28'd0, row_out}, 32'hE);
    check("lit onehot c0",  {16'd0, onehot},  32'h0);
    check("lit key_down c0", {31'd0, key_down}, 32'h0);
    wait_cyc(4);
    check("lit row_out c4", {28'd0, row_out}, 32'hD);

    // Detection tick at cycle 11 (row 2), accepted at tick 19, pulse at 20.
    wait_cyc(19);
    check("lit onehot c19",   {16'd0, onehot},   32'h0);
    check("lit key_down c19", {31'd0, key_down}, 32'h0);
    wait_cyc(20);
    check("lit onehot c20",    {16'd0, onehot},    32'h0100);
    check("lit key_valid c20", {31'd0, key_valid}, 32'h1);
    check("lit key_code c20",  {28'd0, key_code},  32'h8);
    check("lit key_down c20",  {31'd0, key_down},  32'h1);
    wait_cyc(21);
    check("lit onehot c21",    {16'd0, onehot},    32'h0);
    check("lit key_valid c21", {31'd0, key_valid}, 32'h0);

    // Held for 20 ticks, released at cycle 101: all-high ticks 103,107,111.
    wait_cyc(100);
    @(posedge clk);
    #1 pressed = '0;
    wait_cyc(111);
    check("lit key_down c111", {31'd0, key_down}, 32'h1);
    wait_cyc(112);
    check("lit key_down c112", {31'd0, key_down}, 32'h0);
    check("lit row_out c112",  {28'd0, row_out},  32'h7);
`ifndef KEYPAD_REPEAT_EN
    check("lit single pulse", pulses, 1);
`endif

    // Randomized presses, bounces, multi-key, extra keys while held, resets.
    for (int it = 0; it < 400; it++) begin
      @(posedge clk);
      #1;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      hold = $urandom_range(1, 120);
      if (r < 3)       pressed = '0;
      else if (r < 8)  pressed = 16'h1 << a;
      else             pressed = (16'h1 << a) | (16'h1 << b);
      if ($urandom_range(0, 29) == 0) do_reset(2);
      repeat (hold) @(posedge clk);
      if (r == 7) begin
        #1 pressed = pressed | (16'h1 << b);   // second key while possibly held
        repeat ($urandom_range(1, 60)) @(posedge clk);
      end
    end
    #1 pressed = '0;
    repeat (80) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
